// File: rtl/seq_div8_pkg.sv
// Shared ALU definitions: opcodes, datapath width and divider FSM states.
package seq_div8_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] OP_SOMA = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_div8_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep or restore the partial remainder.
module div_step
  import seq_div8_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;

  assign shifted = {rem_i, bit_i};
  // Compare at WIDTH+1 bits; when it fits, the difference is below the
  // divisor, so the low WIDTH bits of the subtraction are exact.
  assign q_o     = (shifted >= {1'b0, divisor_i});
  assign rem_o   = q_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_div8.sv
// Multi-cycle restoring divider (start/done) feeding the ALU divide result.
// Optional two's-complement mode: define SEQ_DIV_SIGNED_EN.
module seq_div8
  import seq_div8_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] dvd_mag, dsr_mag, q_fin, r_fin;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .bit_i    (dvd_q[WIDTH-1]),
    .divisor_i(dsr_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  // The dividend register doubles as the quotient shift register.
  assign q_raw = {dvd_q[WIDTH-2:0], step_q};

`ifdef SEQ_DIV_SIGNED_EN
  logic qneg_q, qneg_d, rneg_q, rneg_d;

  assign dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign dsr_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  // Truncation toward zero: remainder follows the dividend's sign.
  assign q_fin   = qneg_q ? (~q_raw + 1'b1)    : q_raw;
  assign r_fin   = rneg_q ? (~step_rem + 1'b1) : step_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  assign dvd_mag = dividend;
  assign dsr_mag = divisor;
  assign q_fin   = q_raw;
  assign r_fin   = step_rem;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            remo_d  = dividend;
            dbz_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            dvd_d   = dvd_mag;
            dsr_d   = dsr_mag;
            rem_d   = '0;
            cnt_d   = '0;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d  = dividend[WIDTH-1];
`endif
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        dvd_d = q_raw;
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        // Results land in the output regs on the edge into FIN so they
        // are already valid while done is high.
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          quot_d  = q_fin;
          remo_d  = r_fin;
          dbz_d   = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_CALC);
  assign done        = (state_q == S_FIN);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div8.sv
// Scoreboard bench for seq_div8: stimulus pushes expected results, a monitor
// pops and compares them on every done pulse.
module tb_seq_div8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  seq_div8 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         total = 0;
  int         passed = 0;
  logic [7:0] prev_q = '0;
  logic [7:0] prev_r = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) chk("unexpected_done", int'(done), 0);
      else begin
        mon_e = sb.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", div_by_zero, mon_e.dbz);
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edbz, input bit extra);
    int lat;
    logic [15:0] bm, ebm;
    lat = (b == 8'd0) ? 1 : 9;
    bm  = '0;
    ebm = '0;
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back('{eq, er, edbz, cyc + lat});
    for (int k = 1; k <= lat + 2; k++) begin
      @(posedge clk); #1;
      start    = extra && (k == 3 || k == 5);
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      @(negedge clk);
      bm[k] = busy;
      if (k < lat) ebm[k] = 1'b1;
      if (k == 4 && lat == 9) begin
        chk("held_q_during_run", quotient, prev_q);
        chk("held_r_during_run", remainder, prev_r);
      end
    end
    chk("busy_pattern", bm, ebm);
    chk("held_q_after", quotient, eq);
    chk("held_r_after", remainder, er);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    #23 rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_quotient", quotient, 0);
    chk("idle_remainder", remainder, 0);
    chk("idle_dbz", div_by_zero, 0);

`ifdef SEQ_DIV_SIGNED_EN
    do_div(8'hF9, 8'd2,  8'hFD, 8'hFF, 1'b0, 1'b0); // -7 / 2
    do_div(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0); // -128 / -1
    do_div(8'd20, 8'hF9, 8'hFE, 8'h06, 1'b0, 1'b0); // 20 / -7
`else
    do_div(8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 1'b0);
`endif
    do_div(8'd5,   8'd0, 8'hFF, 8'h05, 1'b1, 1'b0);
    do_div(8'd255, 8'd1, 8'hFF, 8'h00, 1'b0, 1'b0);
    do_div(8'd100, 8'd9, 8'd11, 8'd1,  1'b0, 1'b1);

    // Reset in the middle of a 0/3 run: outputs clear at once, no done.
    @(posedge clk); #1;
    start = 1'b1; dividend = 8'd0; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    prev_q = '0;
    prev_r = '0;
    repeat (12) @(posedge clk);
    do_div(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    chk("pending_results", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
